mips_prog_loader: RTL and testbench
===================================

// Module: mips_prog_loader
// PURPOSE
//  Boot-time program loader upstream of the pipelined MIPS32 core. Accepts instruction words on a
//  valid/ready stream and writes them into the core's instruction memory from address 0.
//  Holds the core halted until the image is complete, then clears PC and releases it.
//  Replaces direct bench pokes of mem[], pc and halt with a synthesisable path.
// PARAMETERS
//  ADDR_W      10      imem word-address width
//  MAX_WORDS   1024    image capacity in words (<= 2**ADDR_W)
//  HLT_OPC     6'h3f   opcode [31:26] that terminates the image (HLT = 32'hfc000000)
// PORTS
//  clk1        in   1       single clock, rising edge; core phase-1 clock domain
//  rst_n       in   1       synchronous, active-low reset
//  start       in   1       pulse: begin (re)load; ignored while in LOAD
//  s_valid     in   1       stream word valid
//  s_ready     out  1       loader can accept word
//  s_data      in   32      instruction word
//  s_last      in   1       final word of image
//  imem_we     out  1       imem write strobe
//  imem_addr   out  ADDR_W  imem write address
//  imem_wdata  out  32      imem write data
//  cpu_pc_clr  out  1       one-cycle pulse: core clears pc, branch_taken
//  cpu_run     out  1       1 = core may execute (drives ~halt)
//  done        out  1       image loaded, core running
//  err_ovf     out  1       sticky: image exceeded MAX_WORDS
//  word_cnt    out  ADDR_W+1  words written in current image
// BEHAVIOUR
//  - Reset: state IDLE; every output 0 (s_ready, imem_*, cpu_*, done, err_ovf, word_cnt).
//  - States IDLE -> LOAD -> RELEASE -> RUN; ERR on overflow.
//  - IDLE: s_ready=0. start -> LOAD, word_cnt<=0.
//  - LOAD: s_ready=1. Handshake = s_valid&s_ready. Next cycle: imem_we=1,
//    imem_addr=word_cnt(old), imem_wdata=s_data (registered, latency 1); word_cnt++.
//  - Terminate when accepted word has s_last=1 OR s_data[31:26]==HLT_OPC; that word is written,
//    s_ready drops the next cycle, state -> RELEASE. Both conditions together = one termination.
//  - RELEASE: single cycle; cpu_pc_clr=1, imem_we=0 (final write lands in this cycle's preceding edge).
//  - RUN: cpu_run=1, done=1 (cpu_run rises 2 cycles after final handshake). start -> LOAD:
//    cpu_run and done drop same edge, core halted before any rewrite.
//  - Overflow: handshake while word_cnt==MAX_WORDS and not terminating -> word not written,
//    err_ovf=1, state ERR (s_ready=0, cpu_run=0). Only rst_n or start leaves ERR; start clears err_ovf.
//  - Exactly MAX_WORDS words with last on final word is legal, no error.
//  - s_valid without start (IDLE/RUN): ignored, s_ready=0. start during LOAD ignored.
//  - rst_n low mid-load: abort immediately, partial image stays in imem, core stays halted.
// CONFIGURATION
//  MIPS_LDR_CHKSUM_EN defined: adds out ports chk[31:0] (XOR of all written words, cleared on start)
//  and chk_vld (1 in RUN). Undefined: ports and logic absent; all other behaviour identical.
// STRUCTURE
//  Shared package mips_pkg: opcode constants (HLT_OPC), loader state encoding, instruction width.
//  Single module; no sub-module needed (checksum is one register under the macro).
// TESTING
//  - Load 9 words 00221801,28020014,28030019,0ce77800,0ce77800,00222000,0ce77800,00832800,
//    fc000000 (s_last=0) -> imem[0..8] match, word_cnt=9, cpu_pc_clr 1 pulse, cpu_run=1 2 cycles later.
//  - Same image, MIPS_LDR_CHKSUM_EN -> chk=32'hF065680C, chk_vld=1 in RUN.
//  - s_valid toggling 1/0 each cycle, 4 words, s_last on word 3 -> exactly 4 writes, addr 0..3.
//  - MAX_WORDS=4, 5 words no last -> 4 writes, err_ovf=1, cpu_run stays 0; start clears err_ovf.
//  - rst_n low after 3 words -> all outputs 0 next edge, state IDLE, no further writes.
//  - In RUN, start + 2-word image -> cpu_run falls same edge, imem[0..1] rewritten, run resumes.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS32 constants and program-loader state encoding
package mips_pkg;

  localparam int         INSTR_W = 32;
  localparam logic [5:0] OPC_HLT = 6'h3f;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_ERR     = 3'd4
  } ldr_state_e;

endpackage

// File: rtl/mips_prog_loader.sv
// rtl/mips_prog_loader.sv - boot-time stream-to-imem loader that holds the core halted until the image is in
// Defining MIPS_LDR_CHKSUM_EN adds the chk/chk_vld image checksum ports.
module mips_prog_loader
  import mips_pkg::*;
#(
  parameter int         ADDR_W    = 10,
  parameter int         MAX_WORDS = 1024,
  parameter logic [5:0] HLT_OPC   = OPC_HLT
) (
  input  logic               clk1,
  input  logic               rst_n,
  input  logic               start,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [INSTR_W-1:0] s_data,
  input  logic               s_last,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_pc_clr,
  output logic               cpu_run,
  output logic               done,
  output logic               err_ovf,
  output logic [ADDR_W:0]    word_cnt
`ifdef MIPS_LDR_CHKSUM_EN
  ,
  output logic [INSTR_W-1:0] chk,
  output logic               chk_vld
`endif
);

  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);

  ldr_state_e         state_q;
  logic               s_ready_q;
  logic               imem_we_q;
  logic [ADDR_W-1:0]  imem_addr_q;
  logic [INSTR_W-1:0] imem_wdata_q;
  logic               cpu_pc_clr_q;
  logic               cpu_run_q;
  logic               done_q;
  logic               err_ovf_q;
  logic [ADDR_W:0]    word_cnt_q;
  logic [ADDR_W:0]    word_cnt_d;
`ifdef MIPS_LDR_CHKSUM_EN
  logic [INSTR_W-1:0] chk_q;
  logic               chk_vld_q;
`endif

  logic hs;
  logic term;
  logic ovf;

  // s_ready_q is only ever set while in LOAD, so it alone qualifies the handshake.
  assign hs         = s_valid & s_ready_q;
  assign term       = s_last | (s_data[31:26] == HLT_OPC);
  assign ovf        = (word_cnt_q == MAX_CNT) & ~term;
  assign word_cnt_d = word_cnt_q + (ADDR_W+1)'(1);

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      s_ready_q    <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_pc_clr_q <= 1'b0;
      cpu_run_q    <= 1'b0;
      done_q       <= 1'b0;
      err_ovf_q    <= 1'b0;
      word_cnt_q   <= '0;
`ifdef MIPS_LDR_CHKSUM_EN
      chk_q        <= '0;
      chk_vld_q    <= 1'b0;
`endif
    end else begin
      imem_we_q    <= 1'b0;
      cpu_pc_clr_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_ERR: begin
          if (start) begin
            state_q    <= ST_LOAD;
            s_ready_q  <= 1'b1;
            word_cnt_q <= '0;
            err_ovf_q  <= 1'b0;
`ifdef MIPS_LDR_CHKSUM_EN
            chk_q      <= '0;
`endif
          end
        end
        ST_LOAD: begin
          if (hs) begin
            if (ovf) begin
              state_q   <= ST_ERR;
              s_ready_q <= 1'b0;
              err_ovf_q <= 1'b1;
            end else begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= word_cnt_q[ADDR_W-1:0];
              imem_wdata_q <= s_data;
              word_cnt_q   <= word_cnt_d;
`ifdef MIPS_LDR_CHKSUM_EN
              chk_q        <= chk_q ^ s_data;
`endif
              if (term) begin
                state_q   <= ST_RELEASE;
                s_ready_q <= 1'b0;
              end
            end
          end
        end
        ST_RELEASE: begin
          cpu_pc_clr_q <= 1'b1;
          state_q      <= ST_RUN;
        end
        ST_RUN: begin
          // A reload halts the core on the same edge, before any word is rewritten.
          if (start) begin
            state_q    <= ST_LOAD;
            s_ready_q  <= 1'b1;
            word_cnt_q <= '0;
            cpu_run_q  <= 1'b0;
            done_q     <= 1'b0;
`ifdef MIPS_LDR_CHKSUM_EN
            chk_q      <= '0;
            chk_vld_q  <= 1'b0;
`endif
          end else begin
            cpu_run_q  <= 1'b1;
            done_q     <= 1'b1;
`ifdef MIPS_LDR_CHKSUM_EN
            chk_vld_q  <= 1'b1;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_ready    = s_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_pc_clr = cpu_pc_clr_q;
  assign cpu_run    = cpu_run_q;
  assign done       = done_q;
  assign err_ovf    = err_ovf_q;
  assign word_cnt   = word_cnt_q;
`ifdef MIPS_LDR_CHKSUM_EN
  assign chk        = chk_q;
  assign chk_vld    = chk_vld_q;
`endif

endmodule

// File: tb/tb_mips_prog_loader.sv
// tb/tb_mips_prog_loader.sv - directed self-checking bench for mips_prog_loader
module tb_mips_prog_loader;

  logic        clk1;
  logic        rst_n;
  logic        start, s_valid, s_last;
  logic [31:0] s_data;
  logic        s_ready, imem_we, cpu_pc_clr, cpu_run, done, err_ovf;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [10:0] word_cnt;

  logic        start2, v2, l2;
  logic [31:0] d2;
  logic        s_ready2, imem_we2, cpu_pc_clr2, cpu_run2, done2, err_ovf2;
  logic [1:0]  imem_addr2;
  logic [31:0] imem_wdata2;
  logic [2:0]  word_cnt2;
`ifdef MIPS_LDR_CHKSUM_EN
  logic [31:0] chk, chk2;
  logic        chk_vld, chk_vld2;
`endif

  mips_prog_loader dut (
    .clk1(clk1), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_pc_clr(cpu_pc_clr), .cpu_run(cpu_run), .done(done),
    .err_ovf(err_ovf), .word_cnt(word_cnt)
`ifdef MIPS_LDR_CHKSUM_EN
    , .chk(chk), .chk_vld(chk_vld)
`endif
  );

  mips_prog_loader #(.ADDR_W(2), .MAX_WORDS(4)) dut_small (
    .clk1(clk1), .rst_n(rst_n), .start(start2), .s_valid(v2), .s_ready(s_ready2),
    .s_data(d2), .s_last(l2), .imem_we(imem_we2), .imem_addr(imem_addr2),
    .imem_wdata(imem_wdata2), .cpu_pc_clr(cpu_pc_clr2), .cpu_run(cpu_run2), .done(done2),
    .err_ovf(err_ovf2), .word_cnt(word_cnt2)
`ifdef MIPS_LDR_CHKSUM_EN
    , .chk(chk2), .chk_vld(chk_vld2)
`endif
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic [31:0] mem [0:1023];
  logic [9:0]  wr_addr [0:63];
  int          wr_cnt = 0;
  int          wr2_cnt = 0;
  int          clr_cnt = 0;

  always @(posedge clk1) begin
    if (imem_we === 1'b1) begin
      mem[imem_addr] = imem_wdata;
      wr_addr[wr_cnt[5:0]] = imem_addr;
      wr_cnt++;
    end
    if (imem_we2 === 1'b1) wr2_cnt++;
    if (cpu_pc_clr === 1'b1) clr_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && n < 20) begin
      tick();
      n++;
    end
    check("hs_timeout", n < 20, 1);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  logic [31:0] img [0:8];
  logic [31:0] tog [0:3];
  int base, base2, clr_base;

  initial begin
    img[0] = 32'h00221801; img[1] = 32'h28020014; img[2] = 32'h28030019;
    img[3] = 32'h0ce77800; img[4] = 32'h0ce77800; img[5] = 32'h00222000;
    img[6] = 32'h0ce77800; img[7] = 32'h00832800; img[8] = 32'hfc000000;
    tog[0] = 32'h11110001; tog[1] = 32'h22220002; tog[2] = 32'h33330003; tog[3] = 32'h44440004;

    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    start2 = 1'b0; v2 = 1'b0; l2 = 1'b0; d2 = '0;
    repeat (3) tick();

    check("rst_s_ready", s_ready, 0);
    check("rst_imem_we", imem_we, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_imem_wdata", imem_wdata, 0);
    check("rst_pc_clr", cpu_pc_clr, 0);
    check("rst_cpu_run", cpu_run, 0);
    check("rst_done", done, 0);
    check("rst_err_ovf", err_ovf, 0);
    check("rst_word_cnt", word_cnt, 0);

    rst_n = 1'b1;
    s_valid = 1'b1; s_data = 32'hdeadbeef;
    repeat (3) tick();
    check("idle_ignore_ready", s_ready, 0);
    check("idle_ignore_writes", wr_cnt, 0);
    s_valid = 1'b0;

    // Full 9-word image terminated by HLT opcode, s_last never asserted.
    clr_base = clr_cnt;
    pulse_start();
    check("load_ready", s_ready, 1);
    for (int i = 0; i < 9; i++) send(img[i], 1'b0);
    check("final_we", imem_we, 1);
    check("final_addr", imem_addr, 8);
    check("final_wdata", imem_wdata, 32'hfc000000);
    check("final_ready_drop", s_ready, 0);
    check("img_word_cnt", word_cnt, 9);
    check("final_run_low", cpu_run, 0);
    tick();
    check("release_pc_clr", cpu_pc_clr, 1);
    check("release_we", imem_we, 0);
    check("release_run_low", cpu_run, 0);
    tick();
    check("run_cpu_run", cpu_run, 1);
    check("run_done", done, 1);
    check("run_pc_clr_low", cpu_pc_clr, 0);
    check("img_writes", wr_cnt, 9);
    for (int i = 0; i < 9; i++) check($sformatf("img_mem%0d", i), mem[i], img[i]);
`ifdef MIPS_LDR_CHKSUM_EN
    check("chk_value", chk, 32'hF065680C);
    check("chk_vld", chk_vld, 1);
`endif
    s_valid = 1'b1; s_data = 32'h12345678;
    repeat (3) tick();
    s_valid = 1'b0;
    check("run_ignore_ready", s_ready, 0);
    check("run_ignore_writes", wr_cnt, 9);
    check("pc_clr_pulses", clr_cnt - clr_base, 1);

    // Reload from RUN with a 2-word image.
    base = wr_cnt;
    pulse_start();
    check("reload_run_drop", cpu_run, 0);
    check("reload_done_drop", done, 0);
    check("reload_ready", s_ready, 1);
    check("reload_cnt", word_cnt, 0);
    send(32'h20010005, 1'b0);
    send(32'h2002000a, 1'b1);
    tick();
    tick();
    check("reload_run", cpu_run, 1);
    check("reload_writes", wr_cnt - base, 2);
    check("reload_mem0", mem[0], 32'h20010005);
    check("reload_mem1", mem[1], 32'h2002000a);
    check("reload_mem2_kept", mem[2], 32'h28030019);

    // s_valid toggling, last on the 4th word; a start mid-load is ignored.
    base = wr_cnt;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = tog[i]; s_last = (i == 3);
      tick();
      s_valid = 1'b0; s_last = 1'b0;
      if (i == 1) start = 1'b1;
      tick();
      start = 1'b0;
      if (i == 1) begin
        check("start_in_load_cnt", word_cnt, 2);
        check("start_in_load_ready", s_ready, 1);
      end
    end
    tick();
    check("tog_run", cpu_run, 1);
    check("tog_writes", wr_cnt - base, 4);
    check("tog_cnt", word_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("tog_addr%0d", i), wr_addr[(base + i) % 64], i);
      check($sformatf("tog_mem%0d", i), mem[i], tog[i]);
    end

    // Overflow on a 4-word-capacity loader.
    base2 = wr2_cnt;
    start2 = 1'b1; tick(); start2 = 1'b0;
    v2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d2 = 32'h00000100 + i;
      tick();
    end
    v2 = 1'b0;
    check("ovf_err", err_ovf2, 1);
    check("ovf_ready", s_ready2, 0);
    check("ovf_cnt", word_cnt2, 4);
    check("ovf_we", imem_we2, 0);
    repeat (3) tick();
    check("ovf_writes", wr2_cnt - base2, 4);
    check("ovf_run_low", cpu_run2, 0);
    check("ovf_err_sticky", err_ovf2, 1);
    start2 = 1'b1; tick(); start2 = 1'b0;
    check("ovf_clear", err_ovf2, 0);
    check("ovf_restart_ready", s_ready2, 1);
    check("ovf_restart_cnt", word_cnt2, 0);
    // Exactly MAX_WORDS with last on the final word is legal.
    v2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d2 = 32'h00000200 + i;
      l2 = (i == 3);
      tick();
    end
    v2 = 1'b0; l2 = 1'b0;
    tick();
    tick();
    check("full_run", cpu_run2, 1);
    check("full_no_err", err_ovf2, 0);
    check("full_cnt", word_cnt2, 4);

    // Reset mid-load after 3 words.
    base = wr_cnt;
    pulse_start();
    send(32'h0000aaa1, 1'b0);
    send(32'h0000aaa2, 1'b0);
    send(32'h0000aaa3, 1'b0);
    rst_n = 1'b0;
    tick();
    check("mid_rst_ready", s_ready, 0);
    check("mid_rst_we", imem_we, 0);
    check("mid_rst_addr", imem_addr, 0);
    check("mid_rst_wdata", imem_wdata, 0);
    check("mid_rst_cnt", word_cnt, 0);
    check("mid_rst_run", cpu_run, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_small_run", cpu_run2, 0);
    tick();
    rst_n = 1'b1;
    s_valid = 1'b1; s_data = 32'h0000bbb1;
    repeat (4) tick();
    s_valid = 1'b0;
    check("post_rst_ready", s_ready, 0);
    check("post_rst_writes", wr_cnt - base, 3);
    check("post_rst_run", cpu_run, 0);
    check("partial_mem2", mem[2], 32'h0000aaa3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
